// File: rtl/cb_search_ctrl_if.sv
// Handshake, ROM and result signals between the codebook search sequencer and its neighbours.
interface cb_search_ctrl_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 4
);
    logic              start;
    logic [N-1:0]      target;
    logic [ADDR_W-1:0] rom_addr;
    logic [N-1:0]      rom_data;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] best_index;
    logic [N:0]        best_err;

    modport master (
        output start, target, rom_data,
        input  rom_addr, busy, done, best_index, best_err
    );

    modport slave (
        input  start, target, rom_data,
        output rom_addr, busy, done, best_index, best_err
    );
endinterface

// File: rtl/cb_search_ctrl.sv
// Nearest-entry search over the LSP codebook ROM, one entry per cycle.
// Optional early exit for ascending-sorted codebooks: define CB_MONOTONIC_EXIT_EN.
//
// state | meaning
// IDLE  | waiting for start; results hold the last search
// RUN   | comparing rom_data at rom_addr against the latched target
// DONE  | one-cycle done pulse, best_index/best_err valid
module cb_search_ctrl #(
    parameter int N       = 32,
    parameter int ADDR_W  = 4,
    parameter int CB_SIZE = 16
) (
    input logic            clk,
    input logic            rst,
    cb_search_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CB_SIZE - 1);
    localparam logic [N:0]        MIN_INIT  = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W-1:0] cand_q;
    logic [ADDR_W-1:0] best_index_q;
    logic [N-1:0]      target_q;
    logic [N:0]        run_min_q;
    logic [N:0]        best_err_q;

    logic [N:0] diff;
    logic [N:0] err;
    logic       better;
    logic       last;
    logic       stop;

    // N+1 bit difference of two sign-extended N-bit values cannot overflow
    always_comb begin
        diff   = {target_q[N-1], target_q} - {bus.rom_data[N-1], bus.rom_data};
        err    = diff[N] ? (~diff + {{N{1'b0}}, 1'b1}) : diff;
        better = err < run_min_q;
        last   = rom_addr_q == LAST_ADDR;
`ifdef CB_MONOTONIC_EXIT_EN
        stop   = last || ((rom_addr_q != '0) && (err > run_min_q));
`else
        stop   = last;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (stop) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_addr_q   <= '0;
            cand_q       <= '0;
            best_index_q <= '0;
            target_q     <= '0;
            run_min_q    <= MIN_INIT;
            best_err_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        target_q   <= bus.target;
                        rom_addr_q <= '0;
                        run_min_q  <= MIN_INIT;
                        cand_q     <= '0;
                    end
                end
                RUN: begin
                    if (better) begin
                        run_min_q <= err;
                        cand_q    <= rom_addr_q;
                    end
                    // the final entry's comparison is folded into the published result
                    if (stop) begin
                        best_index_q <= better ? rom_addr_q : cand_q;
                        best_err_q   <= better ? err : run_min_q;
                    end else begin
                        rom_addr_q <= rom_addr_q + 1'b1;
                    end
                end
                DONE:    rom_addr_q <= '0;
                default: rom_addr_q <= '0;
            endcase
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.busy       = state_q != IDLE;
    assign bus.done       = state_q == DONE;
    assign bus.best_index = best_index_q;
    assign bus.best_err   = best_err_q;
endmodule

// File: tb/tb_cb_search_ctrl.sv
// Directed bench for cb_search_ctrl against an ascending 500.0..1250.0 codebook in 50.0 steps.
module tb_cb_search_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   visits[16];
    logic [31:0] rom [16];

    cb_search_ctrl_if #(.N(32), .ADDR_W(4)) bus ();

    cb_search_ctrl #(.N(32), .ADDR_W(4), .CB_SIZE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.rom_data = rom[bus.rom_addr];

`ifdef CB_MONOTONIC_EXIT_EN
    localparam int LAT_700  = 7;
    localparam int HOLD_GAP = 8;
`else
    localparam int LAT_700  = 17;
    localparam int HOLD_GAP = 18;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic run_search(input logic [31:0] tgt, output int edges, output bit seen);
        edges = 0;
        seen  = 1'b0;
        for (int i = 0; i < 16; i++) visits[i] = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.target = tgt;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) seen = 1'b1;
            else if (bus.busy) visits[bus.rom_addr]++;
        end
    endtask

    initial begin
        int  edges;
        bit  seen;
        bit  ok;
        int  ndone;
        int  e1, e2;

        for (int i = 0; i < 16; i++) rom[i] = 32'(500 + 50 * i) << 16;
        bus.start  = 1'b0;
        bus.target = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_addr", 64'(bus.rom_addr), 64'd0);
        chk("rst_idx", 64'(bus.best_index), 64'd0);
        chk("rst_err", 64'(bus.best_err), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // exact match at index 4
        run_search(32'h02BC0000, edges, seen);
        chk("m700_seen", 64'(seen), 64'd1);
        chk("m700_lat", 64'(edges), 64'(LAT_700));
        chk("m700_idx", 64'(bus.best_index), 64'd4);
        chk("m700_err", 64'(bus.best_err), 64'd0);
        chk("m700_busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        chk("m700_pulse", 64'(bus.done), 64'd0);
        chk("m700_idle", 64'(bus.busy), 64'd0);
        chk("m700_addr0", 64'(bus.rom_addr), 64'd0);
        chk("m700_hold_idx", 64'(bus.best_index), 64'd4);

        // below the table
        run_search(32'h00000000, edges, seen);
        chk("zero_seen", 64'(seen), 64'd1);
        chk("zero_idx", 64'(bus.best_index), 64'd0);
        chk("zero_err", 64'(bus.best_err), 64'h01F40000);
        @(negedge clk);

        run_search(32'hFF9C0000, edges, seen);
        chk("neg_seen", 64'(seen), 64'd1);
        chk("neg_idx", 64'(bus.best_index), 64'd0);
        chk("neg_err", 64'(bus.best_err), 64'h02580000);
        @(negedge clk);

        // above the table: every address visited once, full latency in both builds
        run_search(32'h07D00000, edges, seen);
        chk("hi_seen", 64'(seen), 64'd1);
        chk("hi_lat", 64'(edges), 64'd17);
        chk("hi_idx", 64'(bus.best_index), 64'd15);
        chk("hi_err", 64'(bus.best_err), 64'h02EE0000);
        ok = 1'b1;
        for (int i = 0; i < 16; i++) if (visits[i] != 1) ok = 1'b0;
        chk("hi_visits", 64'(ok), 64'd1);
        @(negedge clk);

        // tie between indices 0 and 1 keeps the lower index
        run_search(32'h020D0000, edges, seen);
        chk("tie_seen", 64'(seen), 64'd1);
        chk("tie_idx", 64'(bus.best_index), 64'd0);
        chk("tie_err", 64'(bus.best_err), 64'h00190000);
        @(negedge clk);

        // start pulsed mid-search is ignored
        ndone = 0;
        bus.start  = 1'b1;
        bus.target = 32'h02BC0000;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = (c == 5);
            if (c == 5) bus.target = 32'h07D00000;
            if (bus.done) ndone++;
        end
        bus.start = 1'b0;
        chk("ign_ndone", 64'(ndone), 64'd1);
        chk("ign_idx", 64'(bus.best_index), 64'd4);
        chk("ign_err", 64'(bus.best_err), 64'd0);
        chk("ign_idle", 64'(bus.busy), 64'd0);

        // reset in the middle of a search
        bus.start  = 1'b1;
        bus.target = 32'h07D00000;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("mid_busy_pre", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_busy", 64'(bus.busy), 64'd0);
        chk("mid_done", 64'(bus.done), 64'd0);
        chk("mid_addr", 64'(bus.rom_addr), 64'd0);
        chk("mid_idx", 64'(bus.best_index), 64'd0);
        chk("mid_err", 64'(bus.best_err), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_search(32'h020D0000, edges, seen);
        chk("post_seen", 64'(seen), 64'd1);
        chk("post_idx", 64'(bus.best_index), 64'd0);
        chk("post_err", 64'(bus.best_err), 64'h00190000);
        @(negedge clk);

        // start held high restarts on the first idle cycle after each done
        e1 = -1;
        e2 = -1;
        bus.start  = 1'b1;
        bus.target = 32'h02BC0000;
        for (int c = 1; c <= 60 && e2 < 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                if (e1 < 0) e1 = c;
                else e2 = c;
            end
        end
        bus.start = 1'b0;
        chk("hold_first", 64'(e1), 64'(LAT_700));
        chk("hold_gap", 64'(e2 - e1), 64'(HOLD_GAP));
        chk("hold_idx", 64'(bus.best_index), 64'd4);
        repeat (20) @(negedge clk);
        chk("hold_idle", 64'(bus.busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
